// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port byte-enabled block RAM.
package bram_pkg;

  typedef enum logic {
    RD_READ_FIRST  = 1'b0,
    RD_WRITE_FIRST = 1'b1
  } rd_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } bram_state_e;

  function automatic int unsigned be_width(int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// Per-port read pipeline: rvalid shift register plus an optional second data register.
module bram_port_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  if (READ_LATENCY == 1) begin : g_lat1
    logic valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= accept;
      end
    end

    assign rdata  = word;
    assign rvalid = valid_q;
  end else begin : g_lat2
    logic [1:0]            valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Load only on a stage-1 valid so the output holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        rdata_q <= '0;
      end else begin
        valid_q <= {valid_q[0], accept};
        if (valid_q[0]) begin
          rdata_q <= word;
        end
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = valid_q[1];
  end

endmodule

// File: rtl/bram_dp_be.sv
// True dual-port byte-enabled RAM with a post-reset hardware clear and 1/2-cycle read latency.
module bram_dp_be
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter rd_mode_e    RD_MODE      = RD_READ_FIRST
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  output logic                            init_busy_o,
  input  logic                            a_en_i,
  input  logic                            a_we_i,
  input  logic [be_width(DATA_WIDTH)-1:0] a_be_i,
  input  logic [ADDR_WIDTH-1:0]           a_addr_i,
  input  logic [DATA_WIDTH-1:0]           a_wdata_i,
  output logic [DATA_WIDTH-1:0]           a_rdata_o,
  output logic                            a_rvalid_o,
  input  logic                            b_en_i,
  input  logic                            b_we_i,
  input  logic [be_width(DATA_WIDTH)-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0]           b_addr_i,
  input  logic [DATA_WIDTH-1:0]           b_wdata_i,
  output logic [DATA_WIDTH-1:0]           b_rdata_o,
  output logic                            b_rvalid_o
);

  localparam int unsigned           BeWidth  = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_WORDS - 1);

  if ((DATA_WIDTH % 8) != 0 || NUM_WORDS > 2 ** ADDR_WIDTH ||
      (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_param_check
    $error("bram_dp_be: illegal DATA_WIDTH, NUM_WORDS or READ_LATENCY");
  end

  bram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_we, ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LastAddr) begin
          state_d    = READY;
          clr_addr_d = '0;
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    clr_we      = (state_q == CLEAR) && !rst_i;
    ready       = (state_q == READY) && !rst_i;
    init_busy_o = rst_i || (state_q == CLEAR);
  end

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                 en, we, acc, wr, in_range;
  logic [1:0][BeWidth-1:0]    be;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] wdata, rd_word, rdata_q;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  assign en    = {b_en_i, a_en_i};
  assign we    = {b_we_i, a_we_i};
  assign be    = {b_be_i, a_be_i};
  assign addr  = {b_addr_i, a_addr_i};
  assign wdata = {b_wdata_i, a_wdata_i};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = 32'(addr[p]) < NUM_WORDS;
      acc[p]      = en[p] && ready;
      wr[p]       = acc[p] && we[p] && in_range[p];
    end
  end

  // Port B is written first so that port A owns any byte both ports enable.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= '0;
    end
    for (int p = 1; p >= 0; p--) begin
      if (wr[p]) begin
        for (int k = 0; k < BeWidth; k++) begin
          if (be[p][k]) begin
            mem_q[addr[p]][k*8 +: 8] <= wdata[p][k*8 +: 8];
          end
        end
      end
    end
  end

  // Write-first merges only the port's own write; cross-port reads always see old data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = in_range[p] ? mem_q[addr[p]] : '0;
      if (RD_MODE == RD_WRITE_FIRST && wr[p]) begin
        for (int k = 0; k < BeWidth; k++) begin
          if (be[p][k]) begin
            rd_word[p][k*8 +: 8] = wdata[p][k*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          rdata_q[p] <= rd_word[p];
        end
      end
    end
  end

  bram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk   (clk_i),
    .rst   (rst_i),
    .accept(acc[0]),
    .word  (rdata_q[0]),
    .rdata (a_rdata_o),
    .rvalid(a_rvalid_o)
  );

  bram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk   (clk_i),
    .rst   (rst_i),
    .accept(acc[1]),
    .word  (rdata_q[1]),
    .rdata (b_rdata_o),
    .rvalid(b_rvalid_o)
  );

endmodule

// File: tb/tb_bram_dp_be.sv
// Randomised bench for bram_dp_be: two configurations driven in lockstep against an array model.
module tb_bram_dp_be;
  import bram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic a_en, a_we, b_en, b_we;
  logic [3:0] a_be, b_be;
  logic [7:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [1:0] busy, a_rvalid, b_rvalid;
  logic [1:0][31:0] a_rdata, b_rdata;

  always #5 clk = ~clk;

  bram_dp_be #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(256), .READ_LATENCY(1), .RD_MODE(RD_READ_FIRST)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .init_busy_o(busy[0]),
    .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata[0]), .a_rvalid_o(a_rvalid[0]),
    .b_en_i(b_en), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata[0]), .b_rvalid_o(b_rvalid[0])
  );

  bram_dp_be #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(200), .READ_LATENCY(2), .RD_MODE(RD_WRITE_FIRST)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .init_busy_o(busy[1]),
    .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata[1]), .a_rvalid_o(a_rvalid[1]),
    .b_en_i(b_en), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rdata[1]), .b_rvalid_o(b_rvalid[1])
  );

  // Reference model, one slot per configuration.
  int unsigned nw [2];
  int unsigned lat [2];
  bit          wf [2];
  logic [31:0] mem [2][256];
  int          clr_cnt [2];
  logic [31:0] hold [2][2];
  bit          pend_v [2][2];
  logic [31:0] pend_d [2][2];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
    return r;
  endfunction

  task automatic drive(input int p, input bit en, input bit we, input logic [3:0] be,
                       input logic [7:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      a_en = en; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
    end else begin
      b_en = en; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'h0, 8'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 8'h0, 32'h0);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(196, 205));
    return 8'($urandom_range(0, 11));
  endfunction

  task automatic rand_inputs();
    for (int p = 0; p < 2; p++)
      drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
            rand_addr(), $urandom);
  endtask

  // Advance one clock: update the model from the current inputs, then compare after the edge.
  task automatic step();
    bit pe [2];
    bit pwe [2];
    logic [3:0] pb [2];
    int pad [2];
    logic [31:0] pw [2];
    bit exp_v [2][2];
    pe[0] = a_en; pwe[0] = a_we; pb[0] = a_be; pad[0] = int'(a_addr); pw[0] = a_wdata;
    pe[1] = b_en; pwe[1] = b_we; pb[1] = b_be; pad[1] = int'(b_addr); pw[1] = b_wdata;
    for (int d = 0; d < 2; d++) begin
      bit acc [2];
      logic [31:0] rd [2];
      for (int p = 0; p < 2; p++) begin
        acc[p] = !rst && clr_cnt[d] == 0 && pe[p];
        rd[p] = (pad[p] < int'(nw[d])) ? mem[d][pad[p]] : 32'h0;
        if (wf[d] && pwe[p] && pad[p] < int'(nw[d])) rd[p] = merge(rd[p], pw[p], pb[p]);
      end
      for (int p = 1; p >= 0; p--)
        if (acc[p] && pwe[p] && pad[p] < int'(nw[d]))
          mem[d][pad[p]] = merge(mem[d][pad[p]], pw[p], pb[p]);
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[d][i] = 32'h0;
        clr_cnt[d] = int'(nw[d]);
        for (int p = 0; p < 2; p++) begin
          hold[d][p] = 32'h0; pend_v[d][p] = 0; exp_v[d][p] = 0;
        end
      end else begin
        if (clr_cnt[d] > 0) clr_cnt[d]--;
        for (int p = 0; p < 2; p++) begin
          if (lat[d] == 1) begin
            exp_v[d][p] = acc[p];
            if (acc[p]) hold[d][p] = rd[p];
          end else begin
            exp_v[d][p] = pend_v[d][p];
            if (pend_v[d][p]) hold[d][p] = pend_d[d][p];
            pend_v[d][p] = acc[p];
            pend_d[d][p] = rd[p];
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d busy", d), 32'(busy[d]), 32'(rst || clr_cnt[d] > 0));
      check($sformatf("d%0d a_rvalid", d), 32'(a_rvalid[d]), 32'(exp_v[d][0]));
      check($sformatf("d%0d b_rvalid", d), 32'(b_rvalid[d]), 32'(exp_v[d][1]));
      check($sformatf("d%0d a_rdata", d), a_rdata[d], hold[d][0]);
      check($sformatf("d%0d b_rdata", d), b_rdata[d], hold[d][1]);
    end
  endtask

  task automatic clear_with_traffic(input int n);
    repeat (n) begin
      rand_inputs();
      step();
    end
    idle();
  endtask

  initial begin
    nw[0] = 256; lat[0] = 1; wf[0] = 0;
    nw[1] = 200; lat[1] = 2; wf[1] = 1;
    for (int d = 0; d < 2; d++) begin
      clr_cnt[d] = 0;
      for (int p = 0; p < 2; p++) begin
        hold[d][p] = 32'h0; pend_v[d][p] = 0; pend_d[d][p] = 32'h0;
      end
    end
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    clear_with_traffic(256);

    // Fill with a marker, reset, and confirm the clear wiped it.
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 1, 4'hF, 8'(i), 32'hDEADBEEF);
      step();
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_with_traffic(256);
    foreach (pad_list[i]) begin
      drive(0, 1, 0, 4'h0, pad_list[i], 32'h0);
      step();
      check("clear_read", a_rdata[0], 32'h0);
    end
    idle();
    step();

    // Partial byte-enable write merges into the existing word.
    drive(0, 1, 1, 4'hF, 8'd5, 32'h11223344); step();
    drive(0, 1, 1, 4'h5, 8'd5, 32'hAABBCCDD); step();
    drive(0, 1, 0, 4'h0, 8'd5, 32'h0);        step();
    check("be_merge", a_rdata[0], 32'h11BB33DD);

    // Same-port read-during-write: old data at latency 1, new data with write-first.
    drive(0, 1, 1, 4'hF, 8'd7, 32'h1); step();
    drive(0, 1, 1, 4'hF, 8'd7, 32'h2); step();
    check("rdw_read_first", a_rdata[0], 32'h1);
    idle(); step();
    check("rdw_write_first", a_rdata[1], 32'h2);

    // Same-address collision: A owns byte 0, B supplies byte 1.
    drive(0, 1, 1, 4'h1, 8'd9, 32'h000000AA);
    drive(1, 1, 1, 4'h3, 8'd9, 32'h0000BBCC);
    step();
    idle();
    drive(0, 1, 0, 4'h0, 8'd9, 32'h0); step();
    check("collision", a_rdata[0], 32'h0000BBAA);
    idle();

    // Back-to-back reads on B.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 4'hF, 8'(20 + i), 32'hC0DE0000 + 32'(i)); step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 4'h0, 8'(20 + i), 32'h0); step();
    end
    idle();
    repeat (3) step();
    check("b2b_last", b_rdata[1], 32'hC0DE0003);

    // Reset reasserted partway through the clear.
    rst = 1'b1; step(); rst = 1'b0;
    clear_with_traffic(100);
    rst = 1'b1; step(); rst = 1'b0;
    clear_with_traffic(260);

    // Random dual-port traffic, including out-of-range addresses for the 200-word config.
    clear_with_traffic(1500);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  logic [7:0] pad_list [3] = '{8'd0, 8'd128, 8'd255};

endmodule
